// File: rtl/key_expand_seq.sv
// ---------------------------------------------------------------------------
// key_expand_seq
//
// Sequential AES key-schedule engine. Expands a 128/192/256-bit cipher key
// into Nr+1 round keys, producing one 32-bit schedule word per cycle and
// streaming 128-bit round keys over a valid/ready handshake. rcon is
// generated internally.
//
// Parameters:
//   KEY_BITS  cipher key length (128, 192 or 256)
//   RK_IDX_W  width of rk_index / rd_idx (must be able to hold Nr)
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     begin expansion (sampled only while idle)
//   key_in    cipher key, MSB is the first key byte
//   busy      high from accepted start until the last round key handshakes
//   rk_valid  round key available on rk_data
//   rk_ready  consumer accepts the presented round key
//   rk_data   round key {w[4k], w[4k+1], w[4k+2], w[4k+3]}
//   rk_index  k, index of the presented round key
//   done      one-cycle pulse the cycle after the final handshake
//
// Optional build macro KEY_EXPAND_STORE_EN:
//   Adds a (Nr+1) x 128 round-key store written as keys are emitted, read
//   combinationally through rd_idx -> rd_key (out-of-range index reads 0).
// ---------------------------------------------------------------------------
module key_expand_seq #(
  parameter int KEY_BITS = 128,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk_data,
  output logic [RK_IDX_W-1:0] rk_index,
  output logic                done
`ifdef KEY_EXPAND_STORE_EN
  ,
  input  logic [RK_IDX_W-1:0] rd_idx,
  output logic [127:0]        rd_key
`endif
);

  localparam int NK     = KEY_BITS / 32;
  localparam int NR     = NK + 6;
  localparam int NWORDS = 4 * (NR + 1);
  localparam int CNT_W  = $clog2(NWORDS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  generate
    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
      $error("key_expand_seq: KEY_BITS must be 128, 192 or 256");
    end
    if ((1 << RK_IDX_W) <= NR) begin : g_bad_idx_w
      $error("key_expand_seq: RK_IDX_W too narrow to hold Nr");
    end
  endgenerate

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] word_cnt_reg;
  logic [2:0]       phase_reg;      // i mod Nk, tracked incrementally
  logic [7:0]       rcon_reg;
  logic [31:0]      win_reg [NK];   // win_reg[0] = w[i-Nk], win_reg[NK-1] = w[i-1]
  logic [31:0]      acc_reg [3];    // first three words of the round key in flight

  logic [31:0]      prev_word;
  logic [31:0]      old_word;
  logic [31:0]      sub_in;
  logic [31:0]      sub_out;
  logic [31:0]      t_word;
  logic [31:0]      new_word;
  logic             is_key_word;
  logic             last_of_key;
  logic             last_word;
  logic             rk_fire;
  logic             stall;
  logic             advance;
  logic             load_rk;
  logic [127:0]     load_data;
  logic [RK_IDX_W-1:0] load_idx;

  assign prev_word   = win_reg[NK-1];
  assign old_word    = win_reg[0];
  assign is_key_word = (word_cnt_reg < CNT_W'(NK));
  assign last_of_key = (word_cnt_reg[1:0] == 2'd3);
  assign last_word   = (word_cnt_reg == CNT_W'(NWORDS - 1));
  assign rk_fire     = rk_valid && rk_ready;

  // A word that completes a round key needs the output register to be free
  // (or freed this very cycle); otherwise the whole datapath holds.
  assign stall   = last_of_key && rk_valid && !rk_ready;
  assign advance = (state_reg == ST_EXPAND) && !stall;

  // RotWord only applies on the rcon step (phase 0); the Nk=8 mid-step
  // substitutes without rotation.
  assign sub_in = (phase_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      key_expand_sbox u_sbox (
        .in_byte  (sub_in[8*gi +: 8]),
        .out_byte (sub_out[8*gi +: 8])
      );
    end
  endgenerate

  always_comb begin
    t_word = prev_word;
    if (phase_reg == 3'd0) begin
      t_word = sub_out ^ {rcon_reg, 24'h0};
    end else if (NK == 8 && phase_reg == 3'd4) begin
      t_word = sub_out;
    end
  end

  // During the first Nk words the window is rotated so that, once the key
  // words have been emitted, it again holds w[0..Nk-1] in order.
  assign new_word  = is_key_word ? old_word : (old_word ^ t_word);

  assign load_rk   = advance && last_of_key;
  assign load_data = {acc_reg[0], acc_reg[1], acc_reg[2], new_word};
  assign load_idx  = RK_IDX_W'(word_cnt_reg >> 2);

  // Control, window and rcon
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      word_cnt_reg <= '0;
      phase_reg    <= '0;
      rcon_reg     <= 8'h01;
      busy         <= 1'b0;
      done         <= 1'b0;
      for (int j = 0; j < NK; j++) win_reg[j] <= '0;
      for (int j = 0; j < 3; j++)  acc_reg[j] <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            for (int j = 0; j < NK; j++) win_reg[j] <= key_in[KEY_BITS-1-32*j -: 32];
            word_cnt_reg <= '0;
            phase_reg    <= '0;
            rcon_reg     <= 8'h01;
            busy         <= 1'b1;
            state_reg    <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          if (advance) begin
            for (int j = 0; j < NK - 1; j++) win_reg[j] <= win_reg[j+1];
            win_reg[NK-1] <= new_word;
            acc_reg[0]    <= acc_reg[1];
            acc_reg[1]    <= acc_reg[2];
            acc_reg[2]    <= new_word;
            word_cnt_reg  <= word_cnt_reg + CNT_W'(1);
            phase_reg     <= (phase_reg == 3'(NK - 1)) ? 3'd0 : phase_reg + 3'd1;
            if (!is_key_word && phase_reg == 3'd0) begin
              rcon_reg <= {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
            end
            if (last_word) begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (rk_fire) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Output register: reload and accept may coincide without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_index <= '0;
    end else if (load_rk) begin
      rk_valid <= 1'b1;
      rk_data  <= load_data;
      rk_index <= load_idx;
    end else if (rk_fire) begin
      rk_valid <= 1'b0;
    end
  end

`ifdef KEY_EXPAND_STORE_EN
  logic [127:0] store_reg [NR+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e <= NR; e++) store_reg[e] <= '0;
    end else if (load_rk) begin
      for (int e = 0; e <= NR; e++) begin
        if (load_idx == RK_IDX_W'(e)) store_reg[e] <= load_data;
      end
    end
  end

  // Indices beyond Nr match no entry and read as zero.
  always_comb begin
    rd_key = '0;
    for (int e = 0; e <= NR; e++) begin
      if (rd_idx == RK_IDX_W'(e)) rd_key = store_reg[e];
    end
  end
`endif

endmodule

// ---------------------------------------------------------------------------
// key_expand_sbox
//
// AES forward S-box, one byte, purely combinational lookup.
//
// Ports:
//   in_byte   byte to substitute
//   out_byte  substituted byte
// ---------------------------------------------------------------------------
module key_expand_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX_TABLE[in_byte];

endmodule

// File: tb/tb_key_expand_seq.sv
// ---------------------------------------------------------------------------
// tb_key_expand_seq
//
// Bench for key_expand_seq. One AES-128 instance carries the handshake,
// stall, abort and restart scenarios; AES-192 and AES-256 instances are
// checked against known round keys. Expected AES-128 round keys come from a
// straightforward full-array key expansion and are queued at start.
// ---------------------------------------------------------------------------
module tb_key_expand_seq;

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_X   = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] RK1_A   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_A  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] KEY_192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY_256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // AES-128 instance
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, rk_valid, done;
  logic         rk_ready = 1'b1;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  // AES-192 / AES-256 instances
  logic         start_w = 1'b0;
  logic         ready_w = 1'b1;
  logic         b_busy, b_valid, b_done, c_busy, c_valid, c_done;
  logic [127:0] b_data, c_data;
  logic [3:0]   b_index, c_index;
`ifdef KEY_EXPAND_STORE_EN
  logic [3:0]   rd_idx = '0;
  logic [127:0] rd_key, b_rd_key, c_rd_key;
`endif

  key_expand_seq #(.KEY_BITS(128), .RK_IDX_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_index(rk_index), .done(done)
`ifdef KEY_EXPAND_STORE_EN
    , .rd_idx(rd_idx), .rd_key(rd_key)
`endif
  );

  key_expand_seq #(.KEY_BITS(192), .RK_IDX_W(4)) u_dut192 (
    .clk(clk), .rst(rst), .start(start_w), .key_in(KEY_192), .busy(b_busy),
    .rk_valid(b_valid), .rk_ready(ready_w), .rk_data(b_data),
    .rk_index(b_index), .done(b_done)
`ifdef KEY_EXPAND_STORE_EN
    , .rd_idx(rd_idx), .rd_key(b_rd_key)
`endif
  );

  key_expand_seq #(.KEY_BITS(256), .RK_IDX_W(4)) u_dut256 (
    .clk(clk), .rst(rst), .start(start_w), .key_in(KEY_256), .busy(c_busy),
    .rk_valid(c_valid), .rk_ready(ready_w), .rk_data(c_data),
    .rk_index(c_index), .done(c_done)
`ifdef KEY_EXPAND_STORE_EN
    , .rd_idx(rd_idx), .rd_key(c_rd_key)
`endif
  );

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];
  int   hs_cnt = 0;
  int   done_cnt = 0;
  int   t_start = 0;
  bit   timed = 1'b0;
  bit   stall_prev = 1'b0;
  logic [127:0] prev_data = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  // Reference AES-128 expansion over a full 44-word array.
  function automatic logic [127:0] model_rk(input logic [127:0] key, input int k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]], SBOX[t[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  task automatic push_keys(input logic [127:0] key);
    for (int k = 0; k <= 10; k++) exp_q.push_back('{idx: 4'(k), data: model_rk(key, k)});
  endtask

  // Scoreboard / handshake monitor for the AES-128 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        check("stall_valid", 128'(rk_valid), 128'd1);
        check("stall_data", rk_data, prev_data);
      end
      if (rk_valid && rk_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_key", rk_data, 128'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("rk handshake idx=%0d data=%h cyc=%0d", rk_index, rk_data, cyc - t_start);
          check("rk_index", 128'(rk_index), 128'(e.idx));
          check("rk_data", rk_data, e.data);
          if (timed) begin
            check("rk_cycle", 128'(cyc - t_start), 128'(4 * int'(e.idx) + 5));
            if (e.idx == 4'd1)  check("rk1_vector", rk_data, RK1_A);
            if (e.idx == 4'd10) check("rk10_vector", rk_data, RK10_A);
          end
        end
      end
      if (done) begin
        done_cnt++;
        $display("done pulse cyc=%0d", cyc - t_start);
        if (timed) check("done_cycle", 128'(cyc - t_start), 128'd46);
      end
      stall_prev = rk_valid && !rk_ready;
      prev_data  = rk_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    int d0;
    int h0;
    int hold_cnt;
    bit held;
    logic [127:0] cap_b1, cap_b12, cap_c2, cap_c14;
    cap_b1 = '0; cap_b12 = '0; cap_c2 = '0; cap_c14 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_valid", 128'(rk_valid), 128'd0);
    check("rst_data", rk_data, 128'd0);
    check("rst_index", 128'(rk_index), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    @(posedge clk); #1 rst = 1'b0;

    // AES-192 and AES-256 known-answer runs
    @(posedge clk); #1 start_w = 1'b1;
    @(posedge clk); #1 start_w = 1'b0;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (b_valid && b_index == 4'd1)  cap_b1  = b_data;
      if (b_valid && b_index == 4'd12) cap_b12 = b_data;
      if (c_valid && c_index == 4'd2)  cap_c2  = c_data;
      if (c_valid && c_index == 4'd14) cap_c14 = c_data;
    end
    check("aes192_rk1", cap_b1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    check("aes192_rk12", cap_b12, 128'he98ba06f448c773c8ecc720401002202);
    check("aes256_rk2", cap_c2, 128'h9ba354118e6925afa51a8b5f2067fcde);
    check("aes256_rk14", cap_c14, 128'hfe4890d1e6188d0b046df344706c631e);

    // Run A: AES-128, rk_ready held, latency checked, stray start ignored
    d0 = done_cnt; h0 = hs_cnt;
    @(posedge clk); #1;
    start = 1'b1; key_in = KEY_A; push_keys(KEY_A); t_start = cyc; timed = 1'b1;
    @(negedge clk);
    check("busy_cycle_T", 128'(busy), 128'd0);
    @(posedge clk); #1 start = 1'b0; key_in = KEY_X;
    @(negedge clk);
    check("busy_cycle_T1", 128'(busy), 128'd1);
    for (int n = 0; n < 200 && done_cnt == d0; n++) begin
      @(posedge clk); #1;
      start = (n == 12);
    end
    start = 1'b0;
    timed = 1'b0;
    check("runA_done", 128'(done_cnt - d0), 128'd1);
    check("runA_handshakes", 128'(hs_cnt - h0), 128'd11);
    check("runA_queue_empty", 128'(exp_q.size()), 128'd0);
    @(negedge clk);
    check("runA_busy_low", 128'(busy), 128'd0);
`ifdef KEY_EXPAND_STORE_EN
    rd_idx = 4'd10; #1 check("store_rk10", rd_key, RK10_A);
    rd_idx = 4'd0;  #1 check("store_rk0", rd_key, KEY_A);
    rd_idx = 4'd15; #1 check("store_oob", rd_key, 128'd0);
`endif

    // Run B: random rk_ready, held low 20 cycles once rk3 is presented
    d0 = done_cnt; h0 = hs_cnt; held = 1'b0; hold_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; key_in = KEY_A; push_keys(KEY_A); t_start = cyc;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 600 && done_cnt == d0; n++) begin
      if (hold_cnt > 0) begin
        hold_cnt--;
        rk_ready = 1'b0;
      end else if (!held && rk_valid && rk_index == 4'd3) begin
        held = 1'b1;
        hold_cnt = 19;
        rk_ready = 1'b0;
      end else begin
        rk_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    rk_ready = 1'b1;
    check("runB_hold_applied", 128'(held), 128'd1);
    check("runB_done", 128'(done_cnt - d0), 128'd1);
    check("runB_handshakes", 128'(hs_cnt - h0), 128'd11);
    check("runB_queue_empty", 128'(exp_q.size()), 128'd0);

    // Run C: reset while rk5 is presented, then restart with a new key
    @(posedge clk); #1;
    start = 1'b1; key_in = KEY_A; push_keys(KEY_A); t_start = cyc;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 100 && !(rk_valid && rk_index == 4'd5); n++) begin
      @(posedge clk); #1;
    end
    check("runC_reached_rk5", 128'(rk_valid && rk_index == 4'd5), 128'd1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_valid", 128'(rk_valid), 128'd0);
    check("abort_data", rk_data, 128'd0);
    check("abort_index", 128'(rk_index), 128'd0);
    check("abort_done", 128'(done), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    d0 = done_cnt; h0 = hs_cnt;
    @(posedge clk); #1;
    start = 1'b1; key_in = KEY_B; push_keys(KEY_B); t_start = cyc;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 20 && !rk_valid; n++) begin
      @(posedge clk); #1;
    end
    check("runC_rk0_is_key", rk_data, KEY_B);
    for (int n = 0; n < 200 && done_cnt == d0; n++) begin
      @(posedge clk); #1;
    end
    check("runC_done", 128'(done_cnt - d0), 128'd1);
    check("runC_handshakes", 128'(hs_cnt - h0), 128'd11);
    check("runC_queue_empty", 128'(exp_q.size()), 128'd0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/key_expand_seq.md
Name: key_expand_seq

Overview:
- Sequential, parametrised AES key-schedule engine. Successor to the single-step combinational round-key generator, which took a fixed external rcon.
- Expands a 128/192/256-bit cipher key into all round keys, one 32-bit word per cycle.
- Generates rcon internally.
- Streams 128-bit round keys to the cipher datapath over a valid/ready handshake.
- Sits between the SD-card key register and the AES round pipeline.

Parameters:
- KEY_BITS, 128: cipher key length. Legal values are 128, 192, 256; any other value is an elaboration error. Derived constants: Nk = KEY_BITS/32, Nr = Nk+6.
- RK_IDX_W, 4: width of the round-key index output. Must hold the value Nr.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- start, input, 1: begin expansion. Sampled only in IDLE.
- key_in, input, KEY_BITS: cipher key, MSB = first byte. Latched on accepted start.
- busy, output, 1: high from accepted start until the last round key handshakes.
- rk_valid, output, 1: round key available.
- rk_ready, input, 1: consumer accepts the round key.
- rk_data, output, 128: round key, {w[4k], w[4k+1], w[4k+2], w[4k+3]}.
- rk_index, output, RK_IDX_W: k, the index of the presented round key (0..Nr).
- done, output, 1: one-cycle pulse the cycle after the final handshake.

Behaviour:
- Reset values: busy=0, rk_valid=0, rk_data=0, rk_index=0, done=0. Word counter, rcon, window and accumulator are cleared. State = IDLE.
- Reset mid-operation aborts immediately; no partial round key is presented afterwards.
- States and transitions:
  - IDLE: start=1 latches key_in and goes to EXPAND. busy rises next cycle.
  - EXPAND: produces word i (counter i = 0..4(Nr+1)-1). After the last word, goes to DRAIN.
  - DRAIN: waits for the final rk handshake, then goes to IDLE and pulses done.
- Word rules:
  - i < Nk: w[i] = key word i.
  - Otherwise: w[i] = w[i-Nk] XOR t.
  - t = SubWord(RotWord(w[i-1])) XOR {rcon,24'h0} when i mod Nk == 0.
  - t = SubWord(w[i-1]) when Nk==8 and i mod Nk == 4.
  - Otherwise t = w[i-1].
- Datapath storage: Nk-word sliding shift register. SubWord uses 4 instances of the team's byte s-box.
- rcon: reset and start load 8'h01. After each use it updates to xtime(rcon): rcon<<1, XOR 8'h1B if bit7 was set.
- Accumulator collects 4 words. When word 4k+3 is produced, the accumulator loads the output register (rk_data, rk_index=k, rk_valid=1) if the output register is empty or is being accepted in that same cycle.
- Otherwise EXPAND stalls: counter, window and rcon all hold. Stall relieved the cycle after rk_ready.
- Latency, with start accepted in cycle T and rk_ready held 1: rk_valid for round key k is high in cycle T+4k+5, i.e. a key every 4 cycles.
  - AES-128: last key (k=10) in cycle T+45, done in cycle T+46.
- rk_valid stays high and rk_data stays stable until rk_ready. Simultaneous accept and reload is permitted with no bubble.
- start while busy is ignored; key_in is not re-latched.
- start in the same cycle that done pulses is accepted (state is already IDLE).

Optional Feature:
- Macro: KEY_EXPAND_STORE_EN.
- When defined:
  - Each emitted round key is also written to an internal (Nr+1)x128 register array.
  - Extra ports: rd_idx input RK_IDX_W, rd_key output 128.
  - rd_key is a combinational read of entry rd_idx, so the decryption path can fetch keys in reverse order after done.
  - Entries reset to 0 and are overwritten on the next expansion.
  - rd_idx > Nr returns 0.
- When undefined: the ports and array are absent; no storage is kept.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → rk0 = key; rk1 = a0fafe1788542cb123a339392a6c7605 in cycle T+9; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 in cycle T+45; done in cycle T+46.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → rk1 = 62f8ead2522c6b7bfe0c91f72402f5a5; rk12 = e98ba06f448c773c8ecc720401002202.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → rk2 = 9ba354118e6925afa51a8b5f2067fcde; rk14 = fe4890d1e6188d0b046df344706c631e.
- AES-128 vector above, rk_ready toggled randomly and held 0 for 20 cycles at rk3 → rk_data stable while stalled; key sequence identical to the unstalled run; exactly 11 handshakes.
- rst asserted at rk5; start re-asserted with a new key → all outputs zero during reset; new rk0 equals the new key; no stale keys appear; start pulsed mid-run is ignored.
- With KEY_EXPAND_STORE_EN, after the AES-128 run → rd_idx=10 returns d014f9a8…; rd_idx=15 returns 0.
